// File: rtl/fp_compare_pipe.sv
// Two-stage pipelined IEEE-754 comparator (FEQ/FLT/FLE) with valid/ready handshakes.
// Define FP_COMPARE_FCLASS_EN to make op 11 return the FCLASS mask of operand a.
module fp_compare_pipe #(
  parameter int exp_width  = 8,
  parameter int mant_width = 24
) (
  input  logic                            clk,
  input  logic                            rst_l,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [exp_width+mant_width-1:0] a,
  input  logic [exp_width+mant_width-1:0] b,
  input  logic [1:0]                      op,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [exp_width+mant_width-1:0] out,
  output logic [4:0]                      exceptions
);

  localparam int W  = exp_width + mant_width;
  localparam int FW = mant_width - 1;

  typedef struct packed {
    logic sign;
    logic zero;
    logic inf;
    logic sub;
    logic norm;
    logic qnan;
    logic snan;
  } cls_t;

  function automatic cls_t classify(input logic [W-1:0] x);
    logic [exp_width-1:0] e;
    logic [FW-1:0]        f;
    cls_t                 c;
    e      = x[W-2 -: exp_width];
    f      = x[FW-1:0];
    c.sign = x[W-1];
    c.zero = (e == '0) && (f == '0);
    c.sub  = (e == '0) && (f != '0);
    c.inf  = (&e) && (f == '0);
    c.norm = (e != '0) && !(&e);
    c.qnan = (&e) && f[FW-1];
    c.snan = (&e) && !f[FW-1] && (f != '0);
    return c;
  endfunction

  logic           s1_valid_q, s1_valid_d;
  logic [1:0]     op_q, op_d;
  cls_t           a_cls_q, a_cls_d;
  cls_t           b_cls_q, b_cls_d;
  logic           mag_lt_q, mag_lt_d;
  logic           mag_eq_q, mag_eq_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_q, out_d;
  logic [4:0]     exc_q, exc_d;
  logic           adv2;
  logic           unused_cls;

  assign adv2     = !out_valid_q | out_ready;
  assign in_ready = !s1_valid_q | adv2;

  always_comb begin
    s1_valid_d = s1_valid_q;
    op_d       = op_q;
    a_cls_d    = a_cls_q;
    b_cls_d    = b_cls_q;
    mag_lt_d   = mag_lt_q;
    mag_eq_d   = mag_eq_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (in_valid && in_ready) begin
      op_d     = op;
      a_cls_d  = classify(a);
      b_cls_d  = classify(b);
      mag_lt_d = a[W-2:0] < b[W-2:0];
      mag_eq_d = a[W-2:0] == b[W-2:0];
    end
  end

  // Stage 2: signs and zero/NaN classes turn the unsigned magnitude compare into an IEEE ordering.
  always_comb begin
    logic         any_nan;
    logic         any_snan;
    logic         both_zero;
    logic         a_eq_b;
    logic         a_lt_b;
    logic         cmp;
    logic         nv;
    logic [W-1:0] res;
    logic [9:0]   mask;

    any_nan   = a_cls_q.qnan | a_cls_q.snan | b_cls_q.qnan | b_cls_q.snan;
    any_snan  = a_cls_q.snan | b_cls_q.snan;
    both_zero = a_cls_q.zero & b_cls_q.zero;
    a_eq_b    = both_zero | ((a_cls_q.sign == b_cls_q.sign) & mag_eq_q);
    if (both_zero) begin
      a_lt_b = 1'b0;
    end else if (a_cls_q.sign != b_cls_q.sign) begin
      a_lt_b = a_cls_q.sign;
    end else if (a_cls_q.sign) begin
      a_lt_b = !mag_lt_q & !mag_eq_q;
    end else begin
      a_lt_b = mag_lt_q;
    end

    cmp  = 1'b0;
    nv   = 1'b0;
    res  = '0;
    mask = '0;
    case (op_q)
      2'b00: begin
        cmp = !any_nan & (a_lt_b | a_eq_b);
        nv  = any_nan;
        res = {{(W-1){1'b0}}, cmp};
      end
      2'b01: begin
        cmp = !any_nan & a_lt_b;
        nv  = any_nan;
        res = {{(W-1){1'b0}}, cmp};
      end
      2'b10: begin
        cmp = !any_nan & a_eq_b;
        nv  = any_snan;
        res = {{(W-1){1'b0}}, cmp};
      end
      default: begin
`ifdef FP_COMPARE_FCLASS_EN
        mask[0] = a_cls_q.sign & a_cls_q.inf;
        mask[1] = a_cls_q.sign & a_cls_q.norm;
        mask[2] = a_cls_q.sign & a_cls_q.sub;
        mask[3] = a_cls_q.sign & a_cls_q.zero;
        mask[4] = !a_cls_q.sign & a_cls_q.zero;
        mask[5] = !a_cls_q.sign & a_cls_q.sub;
        mask[6] = !a_cls_q.sign & a_cls_q.norm;
        mask[7] = !a_cls_q.sign & a_cls_q.inf;
        mask[8] = a_cls_q.snan;
        mask[9] = a_cls_q.qnan;
        res     = {{(W-10){1'b0}}, mask};
`else
        res = '0;
`endif
      end
    endcase

    out_valid_d = out_valid_q;
    out_d       = out_q;
    exc_d       = exc_q;
    if (adv2) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_d = res;
        exc_d = {nv, 4'b0000};
      end
    end
  end

  // Infinity/normal/subnormal classes only matter for FCLASS of operand a.
  assign unused_cls = ^{a_cls_q.inf, a_cls_q.sub, a_cls_q.norm,
                        b_cls_q.inf, b_cls_q.sub, b_cls_q.norm};

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      s1_valid_q  <= 1'b0;
      op_q        <= '0;
      a_cls_q     <= '0;
      b_cls_q     <= '0;
      mag_lt_q    <= 1'b0;
      mag_eq_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      exc_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      op_q        <= op_d;
      a_cls_q     <= a_cls_d;
      b_cls_q     <= b_cls_d;
      mag_lt_q    <= mag_lt_d;
      mag_eq_q    <= mag_eq_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      exc_q       <= exc_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out        = out_q;
  assign exceptions = exc_q;

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Testbench for fp_compare_pipe: random traffic checked against a value-ordering model,
// plus directed literal cases for latency, NaN flags, back-pressure and reset.
module tb_fp_compare_pipe;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic [4:0]  exceptions;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [4:0]  exc;
    logic [31:0] out;
  } res_t;

  res_t        exp_q[$];
  bit          stalled = 1'b0;
  logic [31:0] prev_out;
  logic [4:0]  prev_exc;

  fp_compare_pipe #(.exp_width(8), .mant_width(24)) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .op         (op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .exceptions (exceptions)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic bit is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  // Signed ordering key: any two non-NaN floats order exactly like their keys; both zeros map to 0.
  function automatic longint key(input logic [31:0] x);
    longint m;
    m = longint'({33'b0, x[30:0]});
    return x[31] ? -m : m;
  endfunction

`ifdef FP_COMPARE_FCLASS_EN
  function automatic logic [31:0] fclass_ref(input logic [31:0] x);
    int idx;
    if (is_nan(x))                 idx = x[22] ? 9 : 8;
    else if (x[30:23] == 8'hFF)    idx = x[31] ? 0 : 7;
    else if (x[30:0] == 0)         idx = x[31] ? 3 : 4;
    else if (x[30:23] == 8'h00)    idx = x[31] ? 2 : 5;
    else                           idx = x[31] ? 1 : 6;
    return 32'd1 << idx;
  endfunction
`endif

  function automatic res_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    res_t r;
    bit   nan;
    bit   snan;
    nan  = is_nan(x) || is_nan(y);
    snan = (is_nan(x) && !x[22]) || (is_nan(y) && !y[22]);
    r    = '0;
    case (o)
      2'd0: begin r.out[0] = !nan && (key(x) <= key(y)); r.exc[4] = nan;  end
      2'd1: begin r.out[0] = !nan && (key(x) <  key(y)); r.exc[4] = nan;  end
      2'd2: begin r.out[0] = !nan && (key(x) == key(y)); r.exc[4] = snan; end
      default: begin
`ifdef FP_COMPARE_FCLASS_EN
        r.out = fclass_ref(x);
`endif
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] sp [8];
    logic [31:0] s;
    sp = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h7F800000,
           32'h7FC00000, 32'h7F800001, 32'h00000001, 32'h007FFFFF};
    case ($urandom_range(0, 2))
      0:       s = sp[$urandom_range(0, 7)];
      1:       s = $urandom();
      default: s = {1'b0, 8'($urandom_range(120, 130)), 23'($urandom_range(0, 3))};
    endcase
    s[31] = ($urandom_range(0, 1) == 1);
    return s;
  endfunction

  // Compare process: score every output transfer against the model queue and check hold under stall.
  always @(negedge clk) begin
    res_t e;
    if (!rst_l) begin
      exp_q.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check_output("hold_valid", 32'(out_valid), 32'd1);
        check_output("hold_out", out, prev_out);
        check_output("hold_exc", 32'(exceptions), 32'(prev_exc));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_output("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_output("model_out", out, e.out);
          check_output("model_exc", 32'(exceptions), 32'(e.exc));
        end
      end
      stalled  = out_valid && !out_ready;
      prev_out = out;
      prev_exc = exceptions;
      if (in_valid && in_ready) exp_q.push_back(model(op, a, b));
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after the transfer.
  task automatic drive_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = y;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    if (!in_ready) check_output("drive_timeout_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic apply_stimulus(input string name, input logic [1:0] o, input logic [31:0] x,
                                input logic [31:0] y, input logic [31:0] eo, input logic [4:0] ee);
    out_ready = 1'b1;
    drive_op(o, x, y);
    @(negedge clk);
    check_output({name, "_valid_c1"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_output({name, "_valid_c2"}, 32'(out_valid), 32'd1);
    check_output({name, "_out"}, out, eo);
    check_output({name, "_exc"}, 32'(exceptions), 32'(ee));
    @(posedge clk);
    #1;
  endtask

  task automatic backpressure_test();
    logic [1:0]  bo [4];
    logic [31:0] ba [4];
    logic [31:0] bb [4];
    int          sent;
    int          accepts;
    bit          fire;
    bo = '{2'd1, 2'd2, 2'd0, 2'd0};
    ba = '{32'hBF800000, 32'h7F800001, 32'h7FC00000, 32'hFF800000};
    bb = '{32'h3F800000, 32'h3F800000, 32'h00000000, 32'hFF800000};
    sent      = 0;
    accepts   = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op = bo[0]; a = ba[0]; b = bb[0];
    repeat (5) begin
      @(negedge clk);
      fire = in_ready;
      @(posedge clk);
      #1;
      if (fire) begin
        accepts++;
        sent++;
        if (sent < 4) begin op = bo[sent]; a = ba[sent]; b = bb[sent]; end
        else in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check_output("bp_accepts", 32'(accepts), 32'd2);
    check_output("bp_in_ready_low", 32'(in_ready), 32'd0);
    check_output("bp_out_held", out, 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_output("bp_drain_valid", 32'(out_valid), 32'd1);
      fire = in_ready && in_valid;
      @(posedge clk);
      #1;
      if (fire) begin
        sent++;
        if (sent < 4) begin op = bo[sent]; a = ba[sent]; b = bb[sent]; end
        else in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check_output("bp_sent", 32'(sent), 32'd4);
    check_output("bp_drain_done", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_midstream_test();
    out_ready = 1'b0;
    drive_op(2'd1, 32'hBF800000, 32'h3F800000);
    drive_op(2'd2, 32'h7F800001, 32'h3F800000);
    rst_l = 1'b0;
    @(posedge clk);
    #1;
    check_output("rst_mid_valid", 32'(out_valid), 32'd0);
    check_output("rst_mid_out", out, 32'd0);
    check_output("rst_mid_exc", 32'(exceptions), 32'd0);
    check_output("rst_mid_in_ready", 32'(in_ready), 32'd1);
    rst_l     = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_output("rst_no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic random_test(input int cycles);
    bit fired;
    fired    = 1'b0;
    in_valid = 1'b0;
    repeat (cycles) begin
      if (!in_valid || fired) begin
        in_valid = ($urandom_range(0, 9) < 7);
        op       = 2'($urandom_range(0, 3));
        a        = rand_fp();
        case ($urandom_range(0, 7))
          0, 1:    b = a;
          2:       b = a ^ 32'h80000000;
          default: b = rand_fp();
        endcase
      end
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      fired = in_valid && in_ready;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_output("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] fc1;
    logic [31:0] fc2;
    rst_l     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 2'd0;
    a         = 32'h0;
    b         = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset_out_valid", 32'(out_valid), 32'd0);
    check_output("reset_out", out, 32'd0);
    check_output("reset_exc", 32'(exceptions), 32'd0);
    @(posedge clk);
    #1;
    rst_l = 1'b1;
    @(negedge clk);
    check_output("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    apply_stimulus("flt_neg1_pos1", 2'd1, 32'hBF800000, 32'h3F800000, 32'd1, 5'b00000);
    apply_stimulus("fle_negz_posz", 2'd0, 32'h80000000, 32'h00000000, 32'd1, 5'b00000);
    apply_stimulus("feq_negz_posz", 2'd2, 32'h80000000, 32'h00000000, 32'd1, 5'b00000);
    apply_stimulus("feq_qnan",      2'd2, 32'h7FC00000, 32'h3F800000, 32'd0, 5'b00000);
    apply_stimulus("feq_snan",      2'd2, 32'h7F800001, 32'h3F800000, 32'd0, 5'b10000);
    apply_stimulus("flt_qnan",      2'd1, 32'h7FC00000, 32'h00000000, 32'd0, 5'b10000);
    apply_stimulus("flt_neg2_neg1", 2'd1, 32'hC0000000, 32'hBF800000, 32'd1, 5'b00000);
    apply_stimulus("flt_neg1_neg2", 2'd1, 32'hBF800000, 32'hC0000000, 32'd0, 5'b00000);
    apply_stimulus("fle_ninf_ninf", 2'd0, 32'hFF800000, 32'hFF800000, 32'd1, 5'b00000);
    apply_stimulus("flt_pinf_pos1", 2'd1, 32'h7F800000, 32'h3F800000, 32'd0, 5'b00000);

`ifdef FP_COMPARE_FCLASS_EN
    fc1 = 32'h020;
    fc2 = 32'h100;
`else
    fc1 = 32'h0;
    fc2 = 32'h0;
`endif
    apply_stimulus("fclass_subn", 2'd3, 32'h00000001, 32'h7F800001, fc1, 5'b00000);
    apply_stimulus("fclass_snan", 2'd3, 32'h7F800001, 32'h00000000, fc2, 5'b00000);

    backpressure_test();
    reset_midstream_test();
    random_test(2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_compare_pipe.md
Name: fp_compare_pipe

Overview:
- Two-stage pipelined IEEE-754 comparator for the FPU datapath. Implements RISC-V FEQ, FLT and FLE, with FCLASS as an optional build feature.
- Complements the combinational min/max selector. It produces the boolean compare result and the RISC-V exception flags instead of selecting an operand.
- Sits behind the FPU issue logic. Valid/ready handshakes on both the input and output sides, so back-pressure from the writeback arbiter is honoured.

Parameters:
- exp_width, 8, exponent field width.
- mant_width, 24, mantissa width including the hidden bit. Total word width is W = exp_width + mant_width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_l  in  1  synchronous active-low reset.
- in_valid  in  1  operands and op valid this cycle.
- in_ready  out  1  stage 1 can accept a transaction.
- a  in  W  operand A.
- b  in  W  operand B.
- op  in  2  operation select:
  - 00 = FLE
  - 01 = FLT
  - 10 = FEQ
  - 11 = FCLASS (reserved when the optional feature is compiled out)
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out  out  W  result:
  - compare ops: bit 0 = compare result, all other bits 0.
  - FCLASS: 10-bit class mask in bits [9:0].
- exceptions  out  5  flags {NV, DZ, OF, UF, NX}; DZ, OF, UF and NX are always 0.

Behaviour:
- Reset (rst_l low at a clock edge):
  - s1_valid = 0, out_valid = 0, out = 0, exceptions = 0.
  - Any in-flight transaction is dropped with no partial output.
  - in_ready = 1 in the first cycle after reset.
- Handshake:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - out and exceptions hold stable while out_valid & !out_ready.
- Pipeline:
  - adv2 = !out_valid | out_ready.
  - in_ready = !s1_valid | adv2. This path is combinational from out_ready and gives no bubble at full throughput.
  - Stage 1 registers the op plus, for each operand: sign, isZero, isInf, isSubnormal, isNormal, isQNaN, isSNaN. It also registers the magnitude comparisons |a|<|b| and |a|==|b| over bits [W-2:0].
  - Stage 2 computes the result and flags from the stage-1 registers and loads out/exceptions when adv2 & s1_valid.
- Latency and throughput:
  - Latency is 2 cycles from input transfer to out_valid.
  - Throughput is 1 transaction per cycle.
  - Simultaneous input accept and output drain in the same cycle is legal and loses nothing.
- Classification:
  - exp all-ones with frac != 0 is NaN.
  - NaN is quiet (qNaN) when the frac MSB is 1, signaling (sNaN) otherwise.
- Compare rules:
  - +0 and -0 are equal.
  - Signs differ, both operands non-zero: the negative operand is less.
  - Both negative: the ordering of the magnitude compare is reversed.
  - Infinities order normally.
- NaN handling:
  - Any NaN operand forces the compare result to 0.
  - FEQ: NV = 1 only if either operand is sNaN.
  - FLT/FLE: NV = 1 if either operand is any NaN.
- op = 11 with FCLASS_EN undefined: out = 0, exceptions = 0, with normal handshake timing.

Optional Feature:
- Macro: FP_COMPARE_FCLASS_EN.
- Defined: op 11 returns the RISC-V FCLASS mask of operand a in out[9:0], upper bits 0; b is ignored and NV = 0. Mask bits:
  - 0 = -inf
  - 1 = -normal
  - 2 = -subnormal
  - 3 = -0
  - 4 = +0
  - 5 = +subnormal
  - 6 = +normal
  - 7 = +inf
  - 8 = sNaN
  - 9 = qNaN
- Undefined: op 11 behaves as reserved (see Behaviour).

Test Plan:
- Reset mid-stream: issue 2 ops, then assert rst_l = 0 for 1 cycle -> out_valid = 0, out = 0, exceptions = 0; no stale result appears afterwards.
- FLT a=0xBF800000 (-1.0), b=0x3F800000 (1.0) -> out=1, exceptions=0, out_valid in cycle +2. FLE a=0x80000000, b=0x00000000 -> out=1. FEQ on the same operands -> out=1.
- NaN flags:
  - FEQ a=0x7FC00000 (qNaN), b=0x3F800000 -> out=0, exceptions=00000.
  - FEQ a=0x7F800001 (sNaN), b=0x3F800000 -> out=0, exceptions=10000.
  - FLT a=0x7FC00000, b=0 -> out=0, exceptions=10000.
- Negative ordering: FLT a=0xC0000000 (-2.0), b=0xBF800000 (-1.0) -> out=1. FLT with a and b swapped -> out=0. FLE a=0xFF800000 (-inf), b=0xFF800000 -> out=1.
- Back-pressure:
  - Issue 4 back-to-back ops with out_ready=0 -> in_ready falls after 2 accepts and out holds stable.
  - Raise out_ready -> results drain in order, one per cycle, none lost or duplicated.
- With FP_COMPARE_FCLASS_EN: op 11 a=0x00000001 -> out=0x020; a=0x7F800001 -> out=0x100. Without the macro: op 11 -> out=0, exceptions=0.
